// File: rtl/elbeth_load_align_unit_pkg.sv
// Shared encodings for the load-align path: access sizes, FSM states and size decode.
// Size codes double as the LSU's BYTE/HALFWORD/WORD/DWORD encodings.
package elbeth_load_align_unit_pkg;

    localparam logic [3:0] SIZE_BYTE     = 4'd0;
    localparam logic [3:0] SIZE_HALFWORD = 4'd1;
    localparam logic [3:0] SIZE_WORD     = 4'd2;
    localparam logic [3:0] SIZE_DWORD    = 4'd3;

    typedef enum logic [2:0] {
        LAU_IDLE   = 3'd0,
        LAU_ISSUE0 = 3'd1,
        LAU_WAIT0  = 3'd2,
        LAU_ISSUE1 = 3'd3,
        LAU_WAIT1  = 3'd4,
        LAU_DONE   = 3'd5
    } lau_state_e;

    // DWORD only exists on 64-bit builds; anything unrecognised behaves as WORD.
    function automatic int size_nbytes(input logic [3:0] size, input int data_width);
        case (size)
            SIZE_BYTE:     return 1;
            SIZE_HALFWORD: return 2;
            SIZE_DWORD:    return (data_width == 64) ? 8 : 4;
            default:       return 4;
        endcase
    endfunction

endpackage

// File: rtl/elbeth_lane_extract.sv
// Combinational byte-lane extractor: shifts the addressed bytes of a two-word window
// down to lane 0 and zero- or sign-extends them to DATA_WIDTH.
module elbeth_lane_extract
    import elbeth_load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0]         combined,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] off,
    input  logic [3:0]                      size,
    input  logic                            sgn,
    output logic [DATA_WIDTH-1:0]           result
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] raw;
    logic [IDX_W-1:0]      sign_idx;
    logic                  fill;
    int                    nbits;

    always_comb begin
        raw      = DATA_WIDTH'(combined >> {off, 3'b000});
        nbits    = 8 * size_nbytes(size, DATA_WIDTH);
        sign_idx = IDX_W'(nbits - 1);
        fill     = sgn & raw[sign_idx];
        result   = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            result[i] = (i < nbits) ? raw[i] : fill;
    end

endmodule

// File: rtl/elbeth_load_align_unit.sv
// Load-align unit: issues aligned word reads for an LSU load, extracts and extends the bytes.
// Define ELBETH_MISALIGNED_SPLIT_EN to service word-crossing loads with two reads.
module elbeth_load_align_unit
    import elbeth_load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_size,
    input  logic                  req_signed,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_misalign
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);

    lau_state_e state, next_state;

    logic                    ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              size_q;
    logic                    sgn_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    misalign_q;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic [2*DATA_WIDTH-1:0] combined;
    logic [DATA_WIDTH-1:0]   extracted;
    logic                    accept;
    logic                    req_mis;

`ifdef ELBETH_MISALIGNED_SPLIT_EN
    logic                    mis_q;
    logic [DATA_WIDTH-1:0]   word0_q;
`endif

    assign accept    = req_valid & ready_q;
    assign req_ready = ready_q;
    assign out_data  = data_q;
    assign out_misalign = misalign_q;
    assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign req_mis   = (int'(req_addr[OFF_W-1:0]) + size_nbytes(req_size, DATA_WIDTH)) > BYTES;

`ifdef ELBETH_MISALIGNED_SPLIT_EN
    assign combined = (state == LAU_WAIT1) ? {mem_rsp_data, word0_q}
                                           : {{DATA_WIDTH{1'b0}}, mem_rsp_data};
`else
    assign combined = {{DATA_WIDTH{1'b0}}, mem_rsp_data};
`endif

    elbeth_lane_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .combined (combined),
        .off      (addr_q[OFF_W-1:0]),
        .size     (size_q),
        .sgn      (sgn_q),
        .result   (extracted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LAU_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        out_valid     = 1'b0;
        case (state)
            LAU_IDLE: begin
`ifdef ELBETH_MISALIGNED_SPLIT_EN
                if (accept) next_state = LAU_ISSUE0;
`else
                if (accept) next_state = req_mis ? LAU_DONE : LAU_ISSUE0;
`endif
            end
            LAU_ISSUE0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_addr;
                if (mem_req_ready) next_state = LAU_WAIT0;
            end
            LAU_WAIT0: begin
`ifdef ELBETH_MISALIGNED_SPLIT_EN
                if (mem_rsp_valid) next_state = mis_q ? LAU_ISSUE1 : LAU_DONE;
`else
                if (mem_rsp_valid) next_state = LAU_DONE;
`endif
            end
`ifdef ELBETH_MISALIGNED_SPLIT_EN
            LAU_ISSUE1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base_addr + ADDR_WIDTH'(BYTES);  // wraps modulo 2^ADDR_WIDTH
                if (mem_req_ready) next_state = LAU_WAIT1;
            end
            LAU_WAIT1: begin
                if (mem_rsp_valid) next_state = LAU_DONE;
            end
`endif
            LAU_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = LAU_IDLE;
            end
            default: next_state = LAU_IDLE;
        endcase
    end

    // ready is registered so it stays low for the first cycle out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            data_q     <= '0;
            misalign_q <= 1'b0;
`ifdef ELBETH_MISALIGNED_SPLIT_EN
            mis_q      <= 1'b0;
            word0_q    <= '0;
`endif
        end else begin
            ready_q <= (next_state == LAU_IDLE);
            if (accept) begin
                addr_q <= req_addr;
                size_q <= req_size;
                sgn_q  <= req_signed;
                data_q <= '0;
`ifdef ELBETH_MISALIGNED_SPLIT_EN
                mis_q      <= req_mis;
                misalign_q <= 1'b0;
`else
                misalign_q <= req_mis;
`endif
            end
            if (state == LAU_WAIT0 && mem_rsp_valid) begin
`ifdef ELBETH_MISALIGNED_SPLIT_EN
                if (mis_q) word0_q <= mem_rsp_data;
                else       data_q  <= extracted;
`else
                data_q <= extracted;
`endif
            end
`ifdef ELBETH_MISALIGNED_SPLIT_EN
            if (state == LAU_WAIT1 && mem_rsp_valid) data_q <= extracted;
`endif
        end
    end

endmodule

// File: tb/tb_elbeth_load_align_unit.sv
// Bench for elbeth_load_align_unit (32-bit): directed vector table, hand-written corner
// sequences and a randomized phase checked against a byte-level memory model.
module tb_elbeth_load_align_unit;
    import elbeth_load_align_unit_pkg::*;

`ifdef ELBETH_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_signed;
    logic [31:0] req_addr;
    logic [3:0]  req_size;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid, out_ready, out_misalign;
    logic [31:0] out_data;

    always #5 clk = ~clk;

    elbeth_load_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_signed(req_signed),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_misalign(out_misalign)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic [31:0] req_log [$];
    bit          pend = 0;
    logic [31:0] pend_addr;
    bit          rand_stall = 0;
    bit          stall_force = 0;
    bit          stray = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a) >> (8 * int'(a[1:0]));
        return w[7:0];
    endfunction

    // Reference: gather nbytes consecutive memory bytes, then extend arithmetically.
    task automatic model(input logic [31:0] a, input logic [3:0] sz, input bit s,
                         output logic [31:0] d, output bit mis);
        int nb;
        longint v;
        logic [31:0] ba;
        nb  = (sz == SIZE_BYTE) ? 1 : (sz == SIZE_HALFWORD) ? 2 : 4;
        mis = (int'(a[1:0]) + nb) > 4;
        if (mis && !SPLIT) begin
            d = 32'h0;
            return;
        end
        mis = 1'b0;
        v = 0;
        for (int k = 0; k < nb; k++) begin
            ba = a + 32'(k);
            v = v | (longint'(mem_byte(ba)) << (8 * k));
        end
        if (s && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        d = v[31:0];
    endtask

    // Memory responder: one response exactly one cycle after each accepted request.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        mem_req_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            mem_rsp_valid = pend | stray;
            mem_rsp_data  = pend ? mem_word(pend_addr) : $urandom;
            stray = 1'b0;
            pend  = 1'b0;
            mem_req_ready = !stall_force && (!rand_stall || ($urandom_range(0, 2) != 0));
            if (mem_req_valid && mem_req_ready) begin
                pend      = 1'b1;
                pend_addr = mem_req_addr;
                req_log.push_back(mem_req_addr);
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [31:0] a, input logic [3:0] sz, input bit s, input int hold);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("req_ready before request", req_ready, 1);
        req_log.delete();
        req_valid  = 1'b1;
        req_addr   = a;
        req_size   = sz;
        req_signed = s;
        out_ready  = (hold == 0);
        tick();
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_size   = 4'($urandom);
        req_signed = 1'($urandom);
    endtask

    task automatic finish_load(input string tag, input logic [31:0] exp_d, input bit exp_mis,
                               input int hold, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out_data"}, out_data, exp_d);
        check({tag, " out_misalign"}, out_misalign, exp_mis);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " held out_data"}, out_data, exp_d);
            check({tag, " held out_valid"}, out_valid, 1);
            check({tag, " held req_ready"}, req_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check({tag, " out_valid after handshake"}, out_valid, 0);
        check({tag, " req_ready after handshake"}, req_ready, 1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  size;
        bit          sgn;
        logic [31:0] a0, w0, a1, w1;
        logic [31:0] exp_d;
        bit          exp_mis;
        int          exp_lat;
        int          exp_nreq;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic [31:0] addr, input logic [3:0] size, input bit sgn,
                           input logic [31:0] a0, input logic [31:0] w0,
                           input logic [31:0] a1, input logic [31:0] w1,
                           input logic [31:0] exp_d, input bit exp_mis,
                           input int exp_lat, input int exp_nreq);
        vec_t v;
        v.addr = addr; v.size = size; v.sgn = sgn;
        v.a0 = a0; v.w0 = w0; v.a1 = a1; v.w1 = w1;
        v.exp_d = exp_d; v.exp_mis = exp_mis; v.exp_lat = exp_lat; v.exp_nreq = exp_nreq;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] ed, base;
        bit          em;
        int          lat, hold;
        logic [31:0] a;
        logic [3:0]  sz;
        bit          s;

        rst_n = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset req_ready", req_ready, 0);
        check("reset mem_req_valid", mem_req_valid, 0);
        check("reset mem_req_addr", mem_req_addr, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_misalign", out_misalign, 0);
        tick(); tick();
        rst_n = 1'b1;
        check("req_ready low before first edge", req_ready, 0);
        tick();
        check("req_ready one cycle after reset", req_ready, 1);

        add_vec(32'h100, SIZE_WORD, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1);
        add_vec(32'h203, SIZE_BYTE, 1, 32'h200, 32'h80FF7F01, 32'h200, 32'h80FF7F01, 32'hFFFFFF80, 0, 3, 1);
        add_vec(32'h203, SIZE_BYTE, 0, 32'h200, 32'h80FF7F01, 32'h200, 32'h80FF7F01, 32'h00000080, 0, 3, 1);
        add_vec(32'h302, SIZE_HALFWORD, 1, 32'h300, 32'h80011234, 32'h300, 32'h80011234, 32'hFFFF8001, 0, 3, 1);
        add_vec(32'h301, SIZE_BYTE, 1, 32'h300, 32'h80011234, 32'h300, 32'h80011234, 32'h00000012, 0, 3, 1);
        add_vec(32'h300, SIZE_HALFWORD, 0, 32'h300, 32'h80011234, 32'h300, 32'h80011234, 32'h00001234, 0, 3, 1);
        add_vec(32'h101, SIZE_HALFWORD, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'h0000ADBE, 0, 3, 1);
        add_vec(32'h103, SIZE_BYTE, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'h000000DE, 0, 3, 1);
        add_vec(32'h102, SIZE_HALFWORD, 1, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'hFFFFDEAD, 0, 3, 1);
        add_vec(32'h100, 4'hF, 0, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 1);
        add_vec(32'h0FE, SIZE_WORD, 0, 32'h0FC, 32'h3322AAAA, 32'h100, 32'hBBBB5544,
                SPLIT ? 32'h55443322 : 32'h0, !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0);
        add_vec(32'h303, SIZE_HALFWORD, 1, 32'h300, 32'h80011234, 32'h304, 32'h0000007F,
                SPLIT ? 32'h00007F80 : 32'h0, !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0);
        add_vec(32'hFFFFFFFE, SIZE_WORD, 1, 32'hFFFFFFFC, 32'h7766AAAA, 32'h0, 32'hCCCC9988,
                SPLIT ? 32'h99887766 : 32'h0, !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0);

        foreach (vecs[i]) begin
            mem[vecs[i].a0[9:2]] = vecs[i].w0;
            mem[vecs[i].a1[9:2]] = vecs[i].w1;
            start_load(vecs[i].addr, vecs[i].size, vecs[i].sgn, 0);
            finish_load($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_mis, 0, lat);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d mem request count", i), req_log.size(), vecs[i].exp_nreq);
            base = {vecs[i].addr[31:2], 2'b00};
            if (req_log.size() > 0) check($sformatf("vec%0d first mem addr", i), req_log[0], base);
            if (req_log.size() > 1) check($sformatf("vec%0d second mem addr", i), req_log[1], base + 32'd4);
        end

        // output backpressure: result held for 5 cycles, no new request taken
        mem[32'h200 >> 2] = 32'h80FF7F01;
        start_load(32'h203, SIZE_BYTE, 1, 5);
        finish_load("backpressure", 32'hFFFFFF80, 0, 5, lat);

        // memory stall: request address held while mem_req_ready is low
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        stall_force = 1'b1;
        tick(); tick();
        start_load(32'h101, SIZE_BYTE, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("stall mem_req_valid", mem_req_valid, 1);
            check("stall mem_req_addr", mem_req_addr, 32'h100);
            tick();
        end
        stall_force = 1'b0;
        finish_load("stall", 32'h000000BE, 0, 0, lat);

        // reset during WAIT0, then a stray response, then a clean load
        start_load(32'h100, SIZE_WORD, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_data", out_data, 0);
        check("midreset req_ready", req_ready, 0);
        check("midreset mem_req_valid", mem_req_valid, 0);
        check("midreset mem_req_addr", mem_req_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("midreset ready after release", req_ready, 1);
        #2 stray = 1'b1;
        tick(); tick();
        check("stray rsp out_valid", out_valid, 0);
        check("stray rsp mem_req_valid", mem_req_valid, 0);
        check("stray rsp req_ready", req_ready, 1);
        start_load(32'h102, SIZE_HALFWORD, 1, 0);
        finish_load("after reset", 32'hFFFFDEAD, 0, 0, lat);
        check("after reset latency", lat, 3);

        // randomized loads with memory stalls and output backpressure
        rand_stall = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a    = $urandom;
            sz   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
            s    = 1'($urandom);
            hold = $urandom_range(0, 3);
            model(a, sz, s, ed, em);
            start_load(a, sz, s, hold);
            finish_load($sformatf("rand%0d a=%0h sz=%0d s=%0d", i, a, sz, s), ed, em, hold, lat);
        end
        rand_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elbeth_load_align_unit.md
Name: elbeth_load_align_unit

Overview:
- Sequential load-data path between the LSU request and the data-memory port.
- Accepts a load request (address, size, signed), issues aligned word reads to memory and extracts the addressed bytes by lane offset.
- Zero- or sign-extends the result to DATA_WIDTH and returns it over a valid/ready handshake.
- Generalises the combinational extender:
  - parametrised width;
  - address-offset alignment;
  - handshaked, registered output;
  - optional split of misaligned accesses into two reads.

Parameters:
- DATA_WIDTH, 32: memory word and result width; legal values 32 or 64. Byte lanes BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte-address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request valid.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  ADDR_WIDTH  byte address.
- req_size  in  4  access size; `BYTE/`HALFWORD/`WORD encodings from elbeth_definitions.v, plus `DWORD (new) when DATA_WIDTH=64.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_WIDTH  aligned address; low log2(BYTES) bits are always 0.
- mem_rsp_valid  in  1  read data valid; at most one response per accepted request, in order.
- mem_rsp_data  in  DATA_WIDTH  read word, little-endian lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_WIDTH  aligned, extended load result.
- out_misalign  out  1  misaligned-access error flag; qualified by out_valid.

Behaviour:
- Reset (async on rst_n low), all outputs 0:
  - state = IDLE;
  - req_ready, mem_req_valid, out_valid, out_misalign = 0;
  - out_data = 0;
  - mem_req_addr = 0.
- req_ready = 1 one cycle after reset deasserts.
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE.
- Request capture:
  - in IDLE, req_valid & req_ready registers addr, size and signed, then goes to ISSUE0;
  - req_ready is low in every other state.
- Offset and misalignment:
  - off = addr[log2(BYTES)-1:0];
  - nbytes = 1, 2, 4 or 8 per size;
  - misaligned when off + nbytes > BYTES (crosses a word boundary).
- ISSUE0:
  - mem_req_valid = 1, mem_req_addr = addr with offset bits cleared;
  - holds until mem_req_ready, then goes to WAIT0.
- WAIT0:
  - on mem_rsp_valid, capture word0;
  - go to ISSUE1 if misaligned (feature on), else DONE.
- ISSUE1 / WAIT1:
  - same as ISSUE0 / WAIT0 with mem_req_addr = aligned addr + BYTES;
  - capture word1, then go to DONE.
  - Address wrap at 2^ADDR_WIDTH is modulo; no error.
- Extraction:
  - combined = {word1, word0} (word1 = 0 if unused);
  - raw = combined >> (8*off);
  - low nbytes bytes kept;
  - upper bits = bit (8*nbytes-1) replicated if signed, else 0;
  - `WORD on DATA_WIDTH=64 is extended from bit 31.
- DONE:
  - out_valid = 1;
  - out_data and out_misalign are held stable until out_valid & out_ready, then go to IDLE.
  - req_ready rises the cycle after the handshake, so there is no same-cycle back-to-back.
- Latency, aligned access with memory ready and 1-cycle response:
  - request accepted at cycle N;
  - mem_req_valid at N+1;
  - mem_rsp_valid at N+2;
  - out_valid at N+3.
  - A split access adds 2 cycles.
- Unknown req_size: treated as `WORD.
- mem_rsp_valid outside WAIT0/WAIT1: ignored.
- rst_n asserted mid-transaction: immediate return to IDLE, and any in-flight memory response is discarded.

Optional Feature:
- Macro ELBETH_MISALIGNED_SPLIT_EN.
- Defined: a misaligned access performs two reads and merges the words; out_misalign is always 0.
- Undefined:
  - a misaligned access skips memory entirely: IDLE -> DONE the cycle after capture;
  - out_data = 0, out_misalign = 1;
  - ISSUE1/WAIT1 logic is compiled out.

Decomposition:
- elbeth_definitions.v (shared): size encodings `BYTE/`HALFWORD/`WORD/`DWORD and state encodings `LAU_IDLE..`LAU_DONE.
- Sub-module elbeth_lane_extract (combinational):
  - inputs combined words, off, size, signed;
  - output is the extended result;
  - reusable by the store path and the testbench reference model.

Test Plan:
- Aligned word, DATA_WIDTH=32: addr=0x100 returns mem 0xDEADBEEF -> mem_req_addr=0x100, out_data=0xDEADBEEF, out_valid 3 cycles after accept.
- Signed byte: addr=0x103, signed=1, mem word 0x80FF7F01 -> out_data=0xFFFFFF80. With signed=0 -> 0x00000080.
- Halfword at addr 0x102, signed=1, word 0x8001xxxx -> out_data=0xFFFF8001.
- Misaligned word at 0x0FE, words 0x3322xxxx @0x0FC and 0xxxxx5544 @0x100:
  - macro on: two requests 0x0FC, 0x100, out_data=0x55443322;
  - macro off: no mem_req_valid, out_misalign=1, out_data=0.
- Backpressure: out_ready=0 for 5 cycles -> out_data stable, req_ready=0. Also mem_req_ready=0 for 3 cycles -> mem_req_addr held.
- Reset mid-operation: rst_n low during WAIT0 -> all outputs 0 immediately; a late mem_rsp_valid is ignored; the next request completes normally.
